// File: rtl/fft_stream_if.sv
// fft_stream_if: input/output sample streams of the fft frame streamer
interface fft_stream_if #(parameter int DW = 16);
  logic          in_valid;
  logic          in_ready;
  logic [2*DW-1:0] in_data;
  logic          bitrev_en;
  logic          out_valid;
  logic          out_ready;
  logic [2*DW-1:0] out_data;
  logic          out_last;
  modport master (output in_valid, in_data, bitrev_en, out_ready,
                  input  in_ready, out_valid, out_data, out_last);
  modport slave  (input  in_valid, in_data, bitrev_en, out_ready,
                  output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/fft_frame_streamer.sv
// fft_frame_streamer: packs N streamed samples for the fft core, runs it, streams results back out
module fft_frame_streamer #(
  parameter int N        = 8,
  parameter int DW       = 16,
  parameter int CORE_LAT = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  fft_stream_if.slave       s,
  output logic              core_en,
  output logic [N*2*DW-1:0] core_din,
  input  logic [N*2*DW-1:0] core_dout,
  output logic              busy,
  output logic [15:0]       frame_cnt
);
  localparam int LOG2N = $clog2(N);
  localparam int SW    = 2 * DW;
  localparam int LW    = $clog2(CORE_LAT + 1);
  typedef enum logic [1:0] {LOAD, RUN, UNLOAD} state_t;
  state_t              r_state, w_next;
  logic [N*SW-1:0]     r_din, r_obuf;
  logic [LOG2N-1:0]    r_wr_idx, r_rd_idx, w_rev, w_sel;
  logic [LW-1:0]       r_lat_cnt;
  logic                r_bitrev;
  logic [15:0]         r_frame_cnt;
  logic                w_in_xfer, w_out_xfer, w_lat_done, w_last;
  assign w_in_xfer  = s.in_valid && r_state == LOAD;
  assign w_out_xfer = s.out_ready && r_state == UNLOAD;
  assign w_lat_done = r_lat_cnt == LW'(CORE_LAT - 1);
  assign w_last     = r_rd_idx == LOG2N'(N - 1);
  assign w_rev      = {<<{r_rd_idx}};
  assign w_sel      = r_bitrev ? w_rev : r_rd_idx;
  assign core_din   = r_din;
  assign frame_cnt  = r_frame_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LOAD;
      r_din       <= '0;
      r_obuf      <= '0;
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
      r_lat_cnt   <= '0;
      r_bitrev    <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_state   <= w_next;
      r_lat_cnt <= r_state == RUN ? r_lat_cnt + 1'b1 : '0;
      if (w_in_xfer) begin
        r_din[SW*r_wr_idx +: SW] <= s.in_data;
        r_wr_idx                 <= r_wr_idx + 1'b1;
        if (r_wr_idx == '0) r_bitrev <= s.bitrev_en;
      end
      if (r_state == RUN && w_lat_done) begin
        r_obuf   <= core_dout;
        r_rd_idx <= '0;
      end
      if (w_out_xfer) begin
        r_rd_idx <= r_rd_idx + 1'b1;
        if (w_last) r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end
  // out_data is driven from the held index, so it stays put while the sink stalls
  always_comb begin
    w_next      = r_state == LOAD ? (w_in_xfer && r_wr_idx == LOG2N'(N - 1) ? RUN : LOAD) :
                  r_state == RUN  ? (w_lat_done ? UNLOAD : RUN) :
                                    (w_out_xfer && w_last ? LOAD : UNLOAD);
    s.in_ready  = r_state == LOAD;
    s.out_valid = r_state == UNLOAD;
    s.out_last  = r_state == UNLOAD && w_last;
    s.out_data  = r_state == UNLOAD ? r_obuf[SW*w_sel +: SW] : '0;
    core_en     = r_state == RUN;
    busy        = r_state != LOAD;
  end
endmodule

// File: tb/tb_fft_frame_streamer.sv
// tb_fft_frame_streamer: random and directed frames checked against a frame-level reference model
module tb_fft_frame_streamer;
  localparam int N = 8, DW = 16, CORE_LAT = 10, SW = 2 * DW, LOG2N = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  fft_stream_if #(.DW(DW)) s();
  logic core_en, busy;
  logic [N*SW-1:0] core_din, core_dout;
  logic [15:0] frame_cnt;
  fft_frame_streamer #(.N(N), .DW(DW), .CORE_LAT(CORE_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .s(s), .core_en(core_en), .core_din(core_din),
    .core_dout(core_dout), .busy(busy), .frame_cnt(frame_cnt));
  int tests = 0, fails = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int brev(input int i);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) r |= ((i >> b) & 1) << (LOG2N - 1 - b);
    return r;
  endfunction
  // stub core: passthrough that only becomes valid after CORE_LAT-1 enabled edges
  int core_cnt;
  assign core_dout = core_cnt >= CORE_LAT - 1 ? core_din : ~core_din;
  initial forever begin
    @(posedge clk or negedge rst_n);
    core_cnt <= !rst_n ? 0 : core_en ? core_cnt + 1 : 0;
  end
  logic [SW-1:0] m_frame [N];
  int m_loaded = 0, m_run = -1, m_out = -1, m_fc = 0;
  bit m_rev = 1'b0;
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_loaded = 0; m_run = -1; m_out = -1; m_fc = 0; m_rev = 1'b0;
    end else if (m_run < 0 && m_out < 0) begin
      if (s.in_valid) begin
        m_frame[m_loaded] = s.in_data;
        if (m_loaded == 0) m_rev = s.bitrev_en;
        m_loaded++;
        if (m_loaded == N) begin m_loaded = 0; m_run = 0; end
      end
    end else if (m_run >= 0) begin
      m_run++;
      if (m_run == CORE_LAT) begin m_run = -1; m_out = 0; end
    end else if (s.out_ready) begin
      m_out++;
      if (m_out == N) begin m_out = -1; m_fc = (m_fc + 1) & 16'hFFFF; end
    end
  end
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("in_ready", s.in_ready, m_run < 0 && m_out < 0);
      chk("busy", busy, m_run >= 0 || m_out >= 0);
      chk("core_en", core_en, m_run >= 0);
      chk("out_valid", s.out_valid, m_out >= 0);
      chk("frame_cnt", frame_cnt, m_fc);
      if (m_out >= 0) begin
        chk("out_data", s.out_data, m_frame[m_rev ? brev(m_out) : m_out]);
        chk("out_last", s.out_last, m_out == N - 1);
      end
      if (m_run >= 0)
        for (int k = 0; k < N; k++) chk("core_din", core_din[SW*k +: SW], m_frame[k]);
    end
  end
  logic [SW-1:0] got [$];
  int cyc = 0, last_in = 0, lat = 0, en_cnt = 0;
  bit prev_ov = 1'b0;
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst_n && s.in_valid && s.in_ready) last_in = cyc;
    if (rst_n && s.out_valid && !prev_ov) lat = cyc - last_in;
    prev_ov = rst_n && s.out_valid;
    if (rst_n && s.out_valid && s.out_ready) got.push_back(s.out_data);
    if (rst_n && core_en) en_cnt++;
  end
  task automatic send(input logic [SW-1:0] d, input bit br, input bit gaps);
    int t = 0;
    bit acc;
    if (gaps) while ($urandom_range(0, 2) == 0) begin
      s.in_valid = 1'b0; s.in_data = $urandom; s.bitrev_en = $urandom_range(0, 1);
      @(negedge clk);
    end
    s.in_valid = 1'b1; s.in_data = d; s.bitrev_en = br;
    do begin acc = s.in_ready; @(negedge clk); t++; end while (!acc && t < 200);
    chk("in_accept", acc, 1'b1);
  endtask
  task automatic wait_out(input int n);
    int t = 0;
    while (got.size() < n && t < 500) begin @(negedge clk); t++; end
    chk("out_count", got.size(), n);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    s.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  logic [SW-1:0] d [N];
  logic [SW-1:0] sent [$];
  int exp3 [N] = '{1, 5, 3, 7, 2, 6, 4, 8};
  int base, e0, t;
  logic [SW-1:0] held;
  initial begin
    s.in_valid = 1'b0; s.in_data = '0; s.bitrev_en = 1'b0; s.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // reset in the middle of loading a frame
    for (int i = 0; i < 3; i++) send(SW'($urandom), 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", s.in_ready, 1'b1);
    chk("rst_out_valid", s.out_valid, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 16'd0);
    chk("rst_core_din", core_din, '0);
    s.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // natural order
    base = got.size();
    for (int i = 0; i < N; i++) send(SW'((i + 1) << 16), 1'b0, 1'b0);
    s.in_valid = 1'b0;
    wait_out(base + N);
    for (int i = 0; i < N; i++) chk("nat_data", got[base+i], SW'((i + 1) << 16));
    chk("latency", lat, CORE_LAT + 1);
    chk("frame_cnt_1", frame_cnt, 16'd1);
    // bit-reversed, bitrev_en toggled after sample 0
    base = got.size();
    for (int i = 0; i < N; i++) send(SW'((i + 1) << 16), i == 0 ? 1'b1 : i[0], 1'b0);
    s.in_valid = 1'b0;
    wait_out(base + N);
    for (int i = 0; i < N; i++) chk("rev_real", got[base+i][SW-1:DW], exp3[i]);
    // input gaps and an output stall
    base = got.size();
    sent.delete();
    for (int i = 0; i < N; i++) begin d[i] = $urandom; sent.push_back(d[i]); end
    fork
      for (int i = 0; i < N; i++) send(d[i], 1'b0, 1'b1);
      begin
        t = 0;
        while (!s.out_valid && t < 300) begin @(negedge clk); t++; end
        chk("stall_reach", s.out_valid, 1'b1);
        s.out_ready = 1'b0;
        held = s.out_data;
        repeat (5) begin
          @(negedge clk);
          chk("stall_hold", s.out_data, held);
          chk("stall_valid", s.out_valid, 1'b1);
        end
        s.out_ready = 1'b1;
      end
    join
    s.in_valid = 1'b0;
    wait_out(base + N);
    for (int i = 0; i < N; i++) chk("bp_data", got[base+i], sent[i]);
    // impulse with signed extremes
    base = got.size();
    e0 = en_cnt;
    for (int i = 0; i < N; i++) send(i == 0 ? 32'h7FFF_8000 : 32'h0, 1'b0, 1'b0);
    s.in_valid = 1'b0;
    t = 0;
    while (!core_en && t < 20) begin @(negedge clk); t++; end
    chk("imp_core_din", core_din[31:0], 32'h7FFF_8000);
    wait_out(base + N);
    chk("imp_en_cycles", en_cnt - e0, CORE_LAT);
    chk("imp_out0", got[base], 32'h7FFF_8000);
    chk("imp_out1", got[base+1], 32'h0);
    // three back-to-back frames with continuous valid
    do_reset();
    base = got.size();
    sent.delete();
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < N; i++) begin
        held = $urandom;
        sent.push_back(held);
        send(held, 1'b0, 1'b0);
      end
    s.in_valid = 1'b0;
    wait_out(base + 3 * N);
    for (int i = 0; i < 3 * N; i++) chk("b2b_data", got[base+i], sent[i]);
    chk("frame_cnt_3", frame_cnt, 16'd3);
    // random frames, random order, random gaps
    for (int f = 0; f < 6; f++) begin
      base = got.size();
      for (int i = 0; i < N; i++) send(SW'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      s.in_valid = 1'b0;
      wait_out(base + N);
    end
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
